// File: rtl/amul_eval_pkg.sv
// Shared types and constants for the approximate-multiplier error evaluation sequencer.
// Holds the controller state encoding, LFSR polynomial and the exhaustive sweep length.
package amul_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 expressed as register bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;
  localparam int unsigned EXH_SAMPLES    = 65536;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/amul_eval_ctrl_if.sv
// Control, multiplier and result bundle of the error evaluation sequencer.
// master = the environment (host plus multiplier under test), slave = the sequencer.
interface amul_eval_ctrl_if #(
  parameter int unsigned SAMPLE_W = 20
);
  logic                       start;
  logic                       abort;
  logic                       mode;
  logic [15:0]                seed;
  logic [SAMPLE_W-1:0]        num_samples;
  logic [7:0]                 op_a;
  logic [7:0]                 op_b;
  logic [15:0]                prod_in;
  logic                       busy;
  logic                       done;
  logic [SAMPLE_W-1:0]        samples;
  logic [SAMPLE_W-1:0]        err_cnt;
  logic signed [SAMPLE_W+16:0] sum_ed;
  logic [SAMPLE_W+15:0]       sum_ed_abs;
  logic [15:0]                max_ed;

  modport master (
    output start, abort, mode, seed, num_samples, prod_in,
    input  op_a, op_b, busy, done, samples, err_cnt, sum_ed, sum_ed_abs, max_ed
  );

  modport slave (
    input  start, abort, mode, seed, num_samples, prod_in,
    output op_a, op_b, busy, done, samples, err_cnt, sum_ed, sum_ed_abs, max_ed
  );
endinterface

// File: rtl/amul_eval_ctrl_opgen.sv
// Operand generator: 16-bit up-counter (exhaustive sweep, B fastest) or Fibonacci LFSR.
// load takes priority over advance; the mode is captured on load and held for the run.
module amul_opgen
  import amul_eval_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic        mode,
  input  logic [15:0] seed,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b
);

  logic [15:0] val_q, val_d;
  logic        mode_q, mode_d;

  always_comb begin
    val_d  = val_q;
    mode_d = mode_q;
    if (load) begin
      mode_d = mode;
      if (mode) val_d = (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
      else      val_d = 16'h0000;
    end else if (advance) begin
      val_d = mode_q ? lfsr_next(val_q) : val_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= 16'h0000;
      mode_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      mode_q <= mode_d;
    end
  end

  assign op_a = val_q[15:8];
  assign op_b = val_q[7:0];

endmodule

// File: rtl/amul_eval_ctrl.sv
// Error-characterisation sequencer: drives operand pairs to an external approximate
// multiplier, waits MUL_LAT cycles, and accumulates error metrics against exact A*B.
module amul_eval_ctrl
  import amul_eval_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned SAMPLE_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  amul_eval_ctrl_if.slave  bus
);

  localparam int unsigned          SUM_W   = SAMPLE_W + 17;
  localparam int unsigned          ABS_W   = SAMPLE_W + 16;
  localparam logic [7:0]           LAT     = 8'(MUL_LAT);
  localparam logic [SAMPLE_W:0]    EXH_CNT = (SAMPLE_W+1)'(EXH_SAMPLES);
  localparam state_e               RUN_ST  = (MUL_LAT == 0) ? ST_ACC : ST_WAIT;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      mode_q, mode_d;
  logic [SAMPLE_W-1:0]       num_q, num_d;
  logic [SAMPLE_W-1:0]       samples_q, samples_d;
  logic [SAMPLE_W-1:0]       err_cnt_q, err_cnt_d;
  logic signed [SUM_W-1:0]   sum_ed_q, sum_ed_d;
  logic [ABS_W-1:0]          sum_abs_q, sum_abs_d;
  logic [15:0]               max_ed_q, max_ed_d;

  logic                      gen_load, gen_adv;
  logic [7:0]                op_a_w, op_b_w;
  logic [15:0]               exact;
  logic signed [16:0]        ed;
  logic [15:0]               ed_abs;
  logic [SAMPLE_W:0]         next_samples;
  logic                      last;

  function automatic logic [15:0] abs_ed(input logic signed [16:0] v);
    logic signed [16:0] n;
    n = -v;
    return v[16] ? n[15:0] : v[15:0];
  endfunction

  amul_opgen u_opgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .advance (gen_adv),
    .mode    (bus.mode),
    .seed    (bus.seed),
    .op_a    (op_a_w),
    .op_b    (op_b_w)
  );

  assign exact        = 16'(op_a_w) * 16'(op_b_w);
  assign ed           = $signed({1'b0, exact}) - $signed({1'b0, bus.prod_in});
  assign ed_abs       = abs_ed(ed);
  assign next_samples = {1'b0, samples_q} + (SAMPLE_W+1)'(1);
  assign last         = mode_q ? (next_samples == {1'b0, num_q}) : (next_samples == EXH_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    num_d     = num_q;
    samples_d = samples_q;
    err_cnt_d = err_cnt_q;
    sum_ed_d  = sum_ed_q;
    sum_abs_d = sum_abs_q;
    max_ed_d  = max_ed_q;
    gen_load  = 1'b0;
    gen_adv   = 1'b0;

    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            gen_load  = 1'b1;
            mode_d    = bus.mode;
            num_d     = bus.num_samples;
            samples_d = '0;
            err_cnt_d = '0;
            sum_ed_d  = '0;
            sum_abs_d = '0;
            max_ed_d  = '0;
            cnt_d     = '0;
            if (bus.mode && (bus.num_samples == '0)) begin
              state_d = ST_DONE;
            end else begin
              state_d = RUN_ST;
              cnt_d   = LAT;
            end
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_ACC;
        end
        ST_ACC: begin
          samples_d = next_samples[SAMPLE_W-1:0];
          err_cnt_d = err_cnt_q + SAMPLE_W'(ed != 17'sd0);
          sum_ed_d  = sum_ed_q + SUM_W'(ed);
          sum_abs_d = sum_abs_q + ABS_W'(ed_abs);
          if (ed_abs > max_ed_q) max_ed_d = ed_abs;
          if (last) begin
            state_d = ST_DONE;
          end else begin
            gen_adv = 1'b1;
            state_d = RUN_ST;
            cnt_d   = LAT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      num_q     <= '0;
      samples_q <= '0;
      err_cnt_q <= '0;
      sum_ed_q  <= '0;
      sum_abs_q <= '0;
      max_ed_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      samples_q <= samples_d;
      err_cnt_q <= err_cnt_d;
      sum_ed_q  <= sum_ed_d;
      sum_abs_q <= sum_abs_d;
      max_ed_q  <= max_ed_d;
    end
  end

  assign bus.op_a       = op_a_w;
  assign bus.op_b       = op_b_w;
  assign bus.busy       = (state_q == ST_WAIT) || (state_q == ST_ACC);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.samples    = samples_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.sum_ed     = sum_ed_q;
  assign bus.sum_ed_abs = sum_abs_q;
  assign bus.max_ed     = max_ed_q;

endmodule

// File: tb/tb_amul_eval_ctrl.sv
// Bench for amul_eval_ctrl: a MUL_LAT=2 instance for directed/random runs and a
// MUL_LAT=0 instance for the full exhaustive sweep against an LSB-dropping multiplier stub.
module tb_amul_eval_ctrl;
  localparam int SW = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic rst0_n;
  int   sel2;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // 0 exact, 1 zero, 2 exact+1, 3 exact xor (a&b), other: LSB dropped
  function automatic logic [15:0] stub_prod(input int sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] e;
    e = 16'(a) * 16'(b);
    case (sel)
      0:       return e;
      1:       return 16'h0000;
      2:       return e + 16'd1;
      3:       return e ^ {8'h00, a & b};
      default: return e & 16'hFFFE;
    endcase
  endfunction

  amul_eval_ctrl_if #(.SAMPLE_W(SW)) bus2 ();
  amul_eval_ctrl_if #(.SAMPLE_W(SW)) bus0 ();

  assign bus2.prod_in = stub_prod(sel2, bus2.op_a, bus2.op_b);
  assign bus0.prod_in = stub_prod(4, bus0.op_a, bus0.op_b);

  amul_eval_ctrl #(.MUL_LAT(2), .SAMPLE_W(SW)) dut2 (.clk(clk), .rst_n(rst_n),  .bus(bus2));
  amul_eval_ctrl #(.MUL_LAT(0), .SAMPLE_W(SW)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the operand sequence the rules define and accumulate with plain integers.
  task automatic model(input logic m, input logic [15:0] s, input int n, input int sel,
                       output longint e_smp, output longint e_err, output longint e_sum,
                       output longint e_abs, output longint e_max);
    int unsigned l;
    l = (s == 16'h0000) ? 32'hACE1 : 32'(s);
    e_smp = 0; e_err = 0; e_sum = 0; e_abs = 0; e_max = 0;
    for (int i = 0; i < n; i++) begin
      int a, b, ex, p, d, ad;
      if (m) begin a = int'(l >> 8); b = int'(l & 255); end
      else   begin a = i / 256;      b = i % 256;       end
      ex = a * b;
      p  = int'(stub_prod(sel, 8'(a), 8'(b)));
      d  = ex - p;
      ad = (d < 0) ? -d : d;
      e_smp++;
      if (d != 0) e_err++;
      e_sum += d;
      e_abs += ad;
      if (ad > e_max) e_max = ad;
      l = ((l << 1) & 32'hFFFF) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1);
    end
  endtask

  task automatic check_res(input string tag, input longint smp, input longint err,
                           input longint sum, input longint sabs, input longint mx);
    chk({tag, "_samples"}, bus2.samples, smp);
    chk({tag, "_err_cnt"}, bus2.err_cnt, err);
    chk({tag, "_sum_ed"},  bus2.sum_ed, sum);
    chk({tag, "_sum_abs"}, bus2.sum_ed_abs, sabs);
    chk({tag, "_max_ed"},  bus2.max_ed, mx);
  endtask

  task automatic start2(input logic m, input logic [15:0] s, input int n);
    bus2.mode        = m;
    bus2.seed        = s;
    bus2.num_samples = SW'(n);
    bus2.start       = 1'b1;
    @(posedge clk); #1;
    bus2.start       = 1'b0;
  endtask

  task automatic abort2();
    bus2.abort = 1'b1;
    @(posedge clk); #1;
    bus2.abort = 1'b0;
  endtask

  task automatic wait_done2(input int budget, output int cyc);
    cyc = 0;
    while (!bus2.done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_samples2(input int k, input int budget);
    int t;
    t = 0;
    while (int'(bus2.samples) != k && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  initial begin
    longint es, ee, esum, eabs, emax;
    int cyc, cyc2, n, k;
    logic [15:0] sd;

    rst_n = 1'b0; rst0_n = 1'b0; sel2 = 1;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.mode = 1'b0; bus2.seed = '0; bus2.num_samples = '0;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.mode = 1'b0; bus0.seed = '0; bus0.num_samples = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus2.busy, 0);
    chk("rst_done", bus2.done, 0);
    chk("rst_op_a", bus2.op_a, 0);
    chk("rst_op_b", bus2.op_b, 0);
    check_res("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1; rst0_n = 1'b1;
    @(posedge clk); #1;

    // Single LFSR sample against a zero product
    sel2 = 1;
    start2(1'b1, 16'h0102, 1);
    chk("n1_op_a", bus2.op_a, 1);
    chk("n1_op_b", bus2.op_b, 2);
    chk("n1_busy", bus2.busy, 1);
    wait_done2(20, cyc);
    chk("n1_done_cyc", cyc, 3);
    check_res("n1", 1, 1, 2, 2, 2);

    // Zero samples: done immediately, never busy
    abort2();
    chk("abort_done_low", bus2.done, 0);
    start2(1'b1, 16'h1234, 0);
    chk("n0_done", bus2.done, 1);
    chk("n0_busy", bus2.busy, 0);
    check_res("n0", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("n0_busy_later", bus2.busy, 0);

    // Zero seed is replaced
    start2(1'b1, 16'h0000, 1);
    chk("seed0_op_a", bus2.op_a, 8'hAC);
    chk("seed0_op_b", bus2.op_b, 8'hE1);
    wait_done2(20, cyc);
    chk("seed0_done_cyc", cyc, 3);

    // start while busy is ignored
    sel2 = 2;
    sd = 16'($urandom);
    start2(1'b1, sd, 10);
    repeat (7) begin @(posedge clk); #1; end
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    wait_done2(100, cyc);
    chk("ign_done_cyc", cyc + 8, 30);
    check_res("ign", 10, 10, -10, 10, 1);

    // abort after five samples keeps partial accumulators
    start2(1'b1, sd, 10);
    wait_samples2(5, 100);
    chk("abt_reach", bus2.samples, 5);
    abort2();
    chk("abt_busy", bus2.busy, 0);
    chk("abt_done", bus2.done, 0);
    check_res("abt", 5, 5, -5, 5, 1);
    @(posedge clk); #1;
    chk("abt_hold", bus2.samples, 5);

    // randomized LFSR runs against the reference
    sel2 = 3;
    for (int r = 0; r < 6; r++) begin
      sd = 16'($urandom);
      n  = $urandom_range(1, 40);
      start2(1'b1, sd, n);
      wait_done2(200, cyc);
      chk("rnd_done_cyc", cyc, 3 * n);
      model(1'b1, sd, n, 3, es, ee, esum, eabs, emax);
      check_res("rnd", es, ee, esum, eabs, emax);
    end

    // exhaustive mode ignores num_samples; check a random prefix then abort
    k = $urandom_range(5, 60);
    start2(1'b0, 16'h5555, 3);
    chk("exh_op_a0", bus2.op_a, 0);
    chk("exh_op_b0", bus2.op_b, 0);
    wait_samples2(k, 400);
    chk("exh_not_done", bus2.done, 0);
    chk("exh_busy", bus2.busy, 1);
    abort2();
    model(1'b0, 16'h0000, k, 3, es, ee, esum, eabs, emax);
    check_res("exh_pfx", es, ee, esum, eabs, emax);

    // asynchronous reset mid-run, then a fresh run
    sd = 16'($urandom);
    start2(1'b1, sd, 30);
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus2.busy, 0);
    chk("arst_op_a", bus2.op_a, 0);
    chk("arst_op_b", bus2.op_b, 0);
    check_res("arst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sd = 16'($urandom);
    n  = $urandom_range(1, 20);
    start2(1'b1, sd, n);
    wait_done2(200, cyc);
    chk("post_rst_cyc", cyc, 3 * n);
    model(1'b1, sd, n, 3, es, ee, esum, eabs, emax);
    check_res("post_rst", es, ee, esum, eabs, emax);

    // full exhaustive sweep on the zero-latency instance
    bus0.mode  = 1'b0;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    cyc2 = 0;
    while (!bus0.done && cyc2 < 70000) begin
      @(posedge clk); #1;
      cyc2++;
    end
    chk("sweep_done_cyc", cyc2, 65536);
    chk("sweep_samples", bus0.samples, 65536);
    chk("sweep_err_cnt", bus0.err_cnt, 16384);
    chk("sweep_sum_ed", bus0.sum_ed, 16384);
    chk("sweep_sum_abs", bus0.sum_ed_abs, 16384);
    chk("sweep_max_ed", bus0.max_ed, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
